// File: rtl/fir_out_buffer.sv
// FIR output FIFO drained over Wishbone; a pushed sample is poppable via DATA one cycle later, ack one cycle after access.
// Backpressure: fir_stall_o while full, overflowing samples dropped (sticky OVF). FIR_OUT_IRQ_EN adds IRQ_EN and irq_o.
module fir_out_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic [DATA_WIDTH-1:0] fir_y_i,
    input  logic                  fir_valid_i,
    input  logic                  fir_done_i,
    output logic                  fir_stall_o,
    input  logic                  wbs_stb_i,
    input  logic                  wbs_cyc_i,
    input  logic                  wbs_we_i,
    input  logic [3:0]            wbs_sel_i,
    input  logic [31:0]           wbs_adr_i,
    input  logic [31:0]           wbs_dat_i,
    output logic [31:0]           wbs_dat_o,
    output logic                  wbs_ack_o,
    output logic                  irq_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    localparam logic [7:0] ADR_STATUS = 8'h00;
    localparam logic [7:0] ADR_DATA   = 8'h04;
    localparam logic [7:0] ADR_CTRL   = 8'h08;
    localparam logic [7:0] ADR_LEVEL  = 8'h0C;
    localparam logic [7:0] ADR_IRQ_EN = 8'h10;

    typedef enum logic {WB_IDLE, WB_ACK} wb_state_t;
    wb_state_t wb_state, wb_state_nxt;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         count;
    logic                  ovf, done, udf;
    logic                  empty, full;
    logic [7:0]            reg_adr;
    logic                  access, rd_acc, wr_acc, ctrl_wr;
    logic                  push, pop, drop, flush, udf_set;
    logic                  clr_ovf, clr_done, clr_udf;
    logic [31:0]           rd_val;
    logic                  unused_bits;
`ifdef FIR_OUT_IRQ_EN
    logic                  irq_en;
`endif

    assign reg_adr     = wbs_adr_i[7:0];
    assign unused_bits = ^{wbs_adr_i[31:8], wbs_sel_i[3:1], wbs_dat_i[31:4]};

    assign empty       = (count == '0);
    assign full        = (count == FULL_CNT);
    assign fir_stall_o = full;

    // A bus access takes effect on the edge that moves the FSM from IDLE to ACK.
    assign access  = (wb_state == WB_IDLE) && wbs_stb_i && wbs_cyc_i;
    assign rd_acc  = access && !wbs_we_i;
    assign wr_acc  = access && wbs_we_i && wbs_sel_i[0];
    assign ctrl_wr = wr_acc && (reg_adr == ADR_CTRL);

    assign pop      = rd_acc && (reg_adr == ADR_DATA) && !empty;
    assign udf_set  = rd_acc && (reg_adr == ADR_DATA) && empty;
    assign flush    = ctrl_wr && wbs_dat_i[0];
    assign clr_ovf  = ctrl_wr && wbs_dat_i[1];
    assign clr_done = ctrl_wr && wbs_dat_i[2];
    assign clr_udf  = ctrl_wr && wbs_dat_i[3];

    // A full FIFO still accepts a sample when the head leaves on the same edge; flush discards it.
    assign push = fir_valid_i && (!full || pop) && !flush;
    assign drop = fir_valid_i && full && !pop;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wb_state <= WB_IDLE;
        end else begin
            wb_state <= wb_state_nxt;
        end
    end

    always_comb begin
        wb_state_nxt = wb_state;
        case (wb_state)
            WB_IDLE: if (wbs_stb_i && wbs_cyc_i) wb_state_nxt = WB_ACK;
            WB_ACK:  wb_state_nxt = WB_IDLE;
            default: wb_state_nxt = WB_IDLE;
        endcase
    end

    always_comb begin
        wbs_ack_o = (wb_state == WB_ACK);
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (push) mem[wr_ptr] <= fir_y_i;
    end

    // Set events dominate same-cycle clears.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ovf  <= 1'b0;
            done <= 1'b0;
            udf  <= 1'b0;
        end else begin
            ovf  <= drop       | (ovf  & ~clr_ovf);
            done <= fir_done_i | (done & ~clr_done);
            udf  <= udf_set    | (udf  & ~clr_udf);
        end
    end

    always_comb begin
        rd_val = '0;
        case (reg_adr)
            ADR_STATUS: rd_val = {16'h0, 8'(count), 3'b000, udf, done, ovf, full, empty};
            ADR_DATA:   rd_val = empty ? 32'h0 : 32'(mem[rd_ptr]);
            ADR_LEVEL:  rd_val = 32'(count);
`ifdef FIR_OUT_IRQ_EN
            ADR_IRQ_EN: rd_val = {31'h0, irq_en};
`endif
            default:    rd_val = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wbs_dat_o <= '0;
        end else if (access) begin
            wbs_dat_o <= wbs_we_i ? 32'h0 : rd_val;
        end
    end

`ifdef FIR_OUT_IRQ_EN
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            irq_en <= 1'b0;
            irq_o  <= 1'b0;
        end else begin
            if (wr_acc && (reg_adr == ADR_IRQ_EN)) irq_en <= wbs_dat_i[0];
            irq_o <= irq_en & (done | ovf | ~empty);
        end
    end
`else
    assign irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_fir_out_buffer.sv
// Directed plus random bench for fir_out_buffer against a queue-based reference model.
module tb_fir_out_buffer;
    localparam int DEPTH = 8;
    localparam logic [7:0] A_STATUS = 8'h00;
    localparam logic [7:0] A_DATA   = 8'h04;
    localparam logic [7:0] A_CTRL   = 8'h08;
    localparam logic [7:0] A_LEVEL  = 8'h0C;
    localparam logic [7:0] A_IRQEN  = 8'h10;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic [31:0] fir_y_i = '0;
    logic        fir_valid_i = 1'b0;
    logic        fir_done_i = 1'b0;
    logic        fir_stall_o;
    logic        wbs_stb_i = 1'b0;
    logic        wbs_cyc_i = 1'b0;
    logic        wbs_we_i = 1'b0;
    logic [3:0]  wbs_sel_i = '0;
    logic [31:0] wbs_adr_i = '0;
    logic [31:0] wbs_dat_i = '0;
    logic [31:0] wbs_dat_o;
    logic        wbs_ack_o;
    logic        irq_o;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] m_q[$];
    bit          m_ovf, m_done, m_udf;
`ifdef FIR_OUT_IRQ_EN
    bit          m_irq_en;
`endif

    fir_out_buffer #(.DATA_WIDTH(32), .DEPTH(DEPTH)) dut (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_i   (wb_rst_i),
        .fir_y_i    (fir_y_i),
        .fir_valid_i(fir_valid_i),
        .fir_done_i (fir_done_i),
        .fir_stall_o(fir_stall_o),
        .wbs_stb_i  (wbs_stb_i),
        .wbs_cyc_i  (wbs_cyc_i),
        .wbs_we_i   (wbs_we_i),
        .wbs_sel_i  (wbs_sel_i),
        .wbs_adr_i  (wbs_adr_i),
        .wbs_dat_i  (wbs_dat_i),
        .wbs_dat_o  (wbs_dat_o),
        .wbs_ack_o  (wbs_ack_o),
        .irq_o      (irq_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no completion, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ovf  = 1'b0;
        m_done = 1'b0;
        m_udf  = 1'b0;
`ifdef FIR_OUT_IRQ_EN
        m_irq_en = 1'b0;
`endif
    endtask

    // One edge of the register map and FIFO, in terms of the queue; returns the expected read data.
    function automatic logic [31:0] model_step(input bit do_wb, input bit we, input logic [7:0] adr,
                                               input logic [31:0] wd, input logic [3:0] sel,
                                               input bit pv, input logic [31:0] py, input bit dn);
        logic [31:0] r;
        bit ovf_s, udf_s, fl, c_ovf, c_done, c_udf;
        r = '0; ovf_s = 0; udf_s = 0; fl = 0; c_ovf = 0; c_done = 0; c_udf = 0;
        if (do_wb && !we) begin
            case (adr)
                A_STATUS: r = {16'h0, 8'(m_q.size()), 3'b000, m_udf, m_done, m_ovf,
                               (m_q.size() == DEPTH), (m_q.size() == 0)};
                A_DATA: begin
                    if (m_q.size() > 0) r = m_q.pop_front();
                    else udf_s = 1;
                end
                A_LEVEL: r = 32'(m_q.size());
`ifdef FIR_OUT_IRQ_EN
                A_IRQEN: r = {31'h0, m_irq_en};
`endif
                default: r = '0;
            endcase
        end
        if (do_wb && we && sel[0]) begin
            if (adr == A_CTRL) begin
                fl = wd[0]; c_ovf = wd[1]; c_done = wd[2]; c_udf = wd[3];
            end
`ifdef FIR_OUT_IRQ_EN
            if (adr == A_IRQEN) m_irq_en = wd[0];
`endif
        end
        if (pv) begin
            if (m_q.size() == DEPTH) ovf_s = 1;
            else if (!fl) m_q.push_back(py);
        end
        if (fl) m_q.delete();
        m_ovf  = ovf_s | (m_ovf  & ~c_ovf);
        m_done = dn    | (m_done & ~c_done);
        m_udf  = udf_s | (m_udf  & ~c_udf);
        return r;
    endfunction

    task automatic step(input bit do_wb, input bit we, input logic [7:0] adr, input logic [31:0] wd,
                        input logic [3:0] sel, input bit pv, input logic [31:0] py, input bit dn,
                        input string tag);
        logic [31:0] exp_rd;
        logic [31:0] hi;
        chk1({tag, "/stall"}, fir_stall_o, (m_q.size() == DEPTH));
        hi = $urandom();
        wbs_stb_i = do_wb; wbs_cyc_i = do_wb; wbs_we_i = we;
        wbs_adr_i = {hi[31:8], adr}; wbs_dat_i = wd; wbs_sel_i = sel;
        fir_valid_i = pv; fir_y_i = py; fir_done_i = dn;
        exp_rd = model_step(do_wb, we, adr, wd, sel, pv, py, dn);
        @(posedge wb_clk_i); #1;
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
        fir_valid_i = 1'b0; fir_done_i = 1'b0;
        if (do_wb) begin
            chk1({tag, "/ack"}, wbs_ack_o, 1'b1);
            if (!we) chk({tag, "/rd"}, wbs_dat_o, exp_rd);
            @(posedge wb_clk_i); #1;
            chk1({tag, "/ack_once"}, wbs_ack_o, 1'b0);
        end else begin
            chk1({tag, "/no_ack"}, wbs_ack_o, 1'b0);
        end
    endtask

    task automatic push(input logic [31:0] v);
        step(1'b0, 1'b0, 8'h00, 32'h0, 4'h0, 1'b1, v, 1'b0, "push");
    endtask

    task automatic rd(input logic [7:0] a, input string tag);
        step(1'b1, 1'b0, a, 32'h0, 4'hF, 1'b0, 32'h0, 1'b0, tag);
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] sel, input string tag);
        step(1'b1, 1'b1, a, d, sel, 1'b0, 32'h0, 1'b0, tag);
    endtask

    task automatic idle(input bit dn);
        step(1'b0, 1'b0, 8'h00, 32'h0, 4'h0, 1'b0, 32'h0, dn, "idle");
    endtask

    initial begin
        int          op;
        logic [31:0] rv;
        logic [31:0] wd;
        bit          pv_r, dn_r;

        // Reset held with an access pending: the access must never be acknowledged.
        wb_rst_i = 1'b1; wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_adr_i = 32'h4;
        repeat (3) begin
            @(posedge wb_clk_i); #1;
            chk1("rst_ack", wbs_ack_o, 1'b0);
        end
        chk("rst_dat", wbs_dat_o, 32'h0);
        chk1("rst_stall", fir_stall_o, 1'b0);
        chk1("rst_irq", irq_o, 1'b0);
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wb_rst_i = 1'b0;
        model_reset();
        rd(A_STATUS, "rst_status");
        chk("rst_status_val", wbs_dat_o, 32'h0000_0001);

        push(32'h5A);
        rd(A_DATA, "lat_data");
        chk("lat_data_val", wbs_dat_o, 32'h5A);

        push(32'h11); push(32'h22); push(32'h33);
        rd(A_LEVEL, "b3_level");   chk("b3_level_val", wbs_dat_o, 32'h3);
        rd(A_DATA, "b3_d0");       chk("b3_d0_val", wbs_dat_o, 32'h11);
        rd(A_DATA, "b3_d1");       chk("b3_d1_val", wbs_dat_o, 32'h22);
        rd(A_DATA, "b3_d2");       chk("b3_d2_val", wbs_dat_o, 32'h33);
        rd(A_STATUS, "b3_status"); chk("b3_status_val", wbs_dat_o, 32'h0000_0001);

        for (int v = 1; v <= 9; v++) push(32'(v));
        chk1("ovf_stall", fir_stall_o, 1'b1);
        rd(A_STATUS, "ovf_status"); chk("ovf_status_val", wbs_dat_o, 32'h0000_0806);
        for (int v = 1; v <= 8; v++) begin
            rd(A_DATA, "ovf_drain");
            chk("ovf_drain_val", wbs_dat_o, 32'(v));
        end
        wr(A_CTRL, 32'h2, 4'h1, "ovf_clr");
        rd(A_STATUS, "ovf_clr_status"); chk("ovf_clr_status_val", wbs_dat_o, 32'h0000_0001);

        for (int i = 0; i < 8; i++) push(32'hA0 + 32'(i));
        step(1'b1, 1'b0, A_DATA, 32'h0, 4'hF, 1'b1, 32'hBB, 1'b0, "fullrw");
        chk("fullrw_val", wbs_dat_o, 32'hA0);
        rd(A_STATUS, "fullrw_status"); chk("fullrw_status_val", wbs_dat_o, 32'h0000_0802);
        for (int i = 0; i < 8; i++) rd(A_DATA, "fullrw_drain");
        chk("fullrw_last", wbs_dat_o, 32'hBB);

        rd(A_DATA, "udf_data");     chk("udf_data_val", wbs_dat_o, 32'h0);
        rd(A_STATUS, "udf_status"); chk("udf_status_val", wbs_dat_o, 32'h0000_0011);
        wr(A_CTRL, 32'h8, 4'h1, "udf_clr");
        rd(A_STATUS, "udf_clr_st"); chk("udf_clr_st_val", wbs_dat_o, 32'h0000_0001);

        push(32'h5); push(32'h6);
        wr(A_CTRL, 32'h1, 4'hE, "sel_gate");
        rd(A_LEVEL, "sel_level"); chk("sel_level_val", wbs_dat_o, 32'h2);

        step(1'b1, 1'b1, A_CTRL, 32'h1, 4'h1, 1'b1, 32'h44, 1'b0, "flush");
        rd(A_LEVEL, "flush_level");   chk("flush_level_val", wbs_dat_o, 32'h0);
        rd(A_STATUS, "flush_status"); chk("flush_status_val", wbs_dat_o, 32'h0000_0001);
        rd(A_DATA, "flush_data");     chk("flush_data_val", wbs_dat_o, 32'h0);
        wr(A_CTRL, 32'h8, 4'h1, "flush_udf_clr");

        idle(1'b1);
        rd(A_STATUS, "done_status"); chk("done_status_val", wbs_dat_o, 32'h0000_0009);
        wr(A_CTRL, 32'h4, 4'h1, "done_clr");
        rd(A_STATUS, "done_clr_st"); chk("done_clr_st_val", wbs_dat_o, 32'h0000_0001);

        push(32'h7);
        rd(8'h20, "unmapped_rd"); chk("unmapped_rd_val", wbs_dat_o, 32'h0);
        wr(8'h24, 32'hFFFF_FFFF, 4'hF, "unmapped_wr");
        rd(A_LEVEL, "unmapped_level"); chk("unmapped_level_val", wbs_dat_o, 32'h1);
        rd(A_DATA, "unmapped_drain");  chk("unmapped_drain_val", wbs_dat_o, 32'h7);

`ifdef FIR_OUT_IRQ_EN
        wr(A_IRQEN, 32'h1, 4'h1, "irq_en_wr");
        rd(A_IRQEN, "irq_en_rd"); chk("irq_en_rd_val", wbs_dat_o, 32'h1);
        idle(1'b0);
        chk1("irq_quiet", irq_o, 1'b0);
        idle(1'b1);
        idle(1'b0);
        chk1("irq_done", irq_o, 1'b1);
        wr(A_CTRL, 32'h4, 4'h1, "irq_clr");
        chk1("irq_cleared", irq_o, 1'b0);
        wr(A_IRQEN, 32'h0, 4'h1, "irq_en_off");
`else
        rd(A_IRQEN, "irq_en_unmapped"); chk("irq_en_unmapped_val", wbs_dat_o, 32'h0);
        idle(1'b1);
        idle(1'b0);
        chk1("irq_tied", irq_o, 1'b0);
        wr(A_CTRL, 32'h4, 4'h1, "irq_tied_clr");
`endif

        // Reset landing on an access edge aborts the access.
        push(32'h1); push(32'h2);
        wbs_adr_i = {24'h0, A_DATA}; wbs_we_i = 1'b0; wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1;
        wb_rst_i = 1'b1;
        @(posedge wb_clk_i); #1;
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wb_rst_i = 1'b0;
        chk1("midrst_ack", wbs_ack_o, 1'b0);
        model_reset();
        rd(A_LEVEL, "midrst_level"); chk("midrst_level_val", wbs_dat_o, 32'h0);

        for (int i = 0; i < 400; i++) begin
            op   = int'($urandom_range(0, 9));
            rv   = $urandom();
            pv_r = ($urandom_range(0, 2) == 0);
            dn_r = ($urandom_range(0, 7) == 0);
            case (op)
                0, 1, 2, 3: step(1'b0, 1'b0, 8'h00, 32'h0, 4'h0, 1'b1, rv, dn_r, "rnd_push");
                4, 5: step(1'b1, 1'b0, A_DATA, 32'h0, 4'hF, pv_r, rv, dn_r, "rnd_data");
                6: step(1'b1, 1'b0, A_STATUS, 32'h0, 4'hF, pv_r, rv, dn_r, "rnd_status");
                7: step(1'b1, 1'b0, A_LEVEL, 32'h0, 4'hF, pv_r, rv, dn_r, "rnd_level");
                8: begin
                    wd = {28'h0, 3'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0)};
                    step(1'b1, 1'b1, A_CTRL, wd, 4'($urandom_range(0, 15)), pv_r, rv, dn_r, "rnd_ctrl");
                end
                default: step(1'b1, 1'($urandom_range(0, 1)), 8'h20 + 8'($urandom_range(0, 20)) * 8'd4,
                              rv, 4'hF, pv_r, rv, dn_r, "rnd_unmapped");
            endcase
`ifndef FIR_OUT_IRQ_EN
            chk1("rnd_irq", irq_o, 1'b0);
`endif
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
